// File: rtl/scope_pkg.sv
// Shared definitions for the triggered waveform-capture buffer:
// trigger-mode encodings, capture state enumeration and size defaults.
package scope_pkg;

  localparam int DEF_DATA_W     = 24;
  localparam int DEF_DEPTH_LOG2 = 10;
  localparam int DEF_DECIM_W    = 8;

  localparam logic [1:0] TRIG_RISE = 2'd0;
  localparam logic [1:0] TRIG_FALL = 2'd1;
  localparam logic [1:0] TRIG_FREE = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT,
    ST_POST,
    ST_DONE
  } state_t;

endpackage

// File: rtl/scope_ram.sv
// Simple dual-port frame memory: one write port, one registered read port.
// Only the read register is reset; the array contents are not.
module scope_ram #(
  parameter int W  = 48,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [0:(1<<AW)-1];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/scope_capture.sv
// Triggered stereo capture: decimate, keep DEPTH/2 pre-trigger history in a ring,
// detect a level crossing, then freeze one frame for trigger-relative readout.
module scope_capture
  import scope_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int DECIM_W    = DEF_DECIM_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] audio_l,
  input  logic signed [DATA_W-1:0] audio_r,
  input  logic                     chan_sel,
  input  logic [1:0]               trig_mode,
  input  logic signed [DATA_W-1:0] trig_level,
  input  logic [DECIM_W-1:0]       decim,
  input  logic                     arm,
  input  logic [DEPTH_LOG2-1:0]    rd_addr,
  output logic [2*DATA_W-1:0]      rd_data,
  output logic                     frame_ready,
  output logic                     busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] HALF    = DEPTH_LOG2'(DEPTH / 2);
  localparam logic [DEPTH_LOG2-1:0] HALF_M1 = DEPTH_LOG2'(DEPTH / 2 - 1);

  state_t                  state_q;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, trig_ptr_q, pre_cnt_q, post_cnt_q;
  logic [DECIM_W-1:0]      dec_cnt_q;
  logic                    prev_above_q, prev_valid_q;
  logic                    frame_ready_q, busy_q;

  logic signed [DATA_W-1:0] trig_x;
  logic                     above, hit, store_d;
  logic [DEPTH_LOG2-1:0]    raddr_d;

  function automatic logic edge_hit(input logic [1:0] mode, input logic pv,
                                    input logic pa, input logic a);
    case (mode)
      TRIG_RISE: edge_hit = pv && !pa && a;
      TRIG_FALL: edge_hit = pv && pa && !a;
      TRIG_FREE: edge_hit = 1'b1;
      default:   edge_hit = 1'b1;
    endcase
  endfunction

  assign trig_x  = chan_sel ? audio_r : audio_l;
  assign above   = (trig_x >= trig_level);
  assign hit     = edge_hit(trig_mode, prev_valid_q, prev_above_q, above);
  // arm has priority: a sample arriving with arm is dropped
  assign store_d = busy_q && sample_valid && !arm && (dec_cnt_q == '0);
  assign raddr_d = trig_ptr_q - HALF + rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      trig_ptr_q    <= '0;
      pre_cnt_q     <= '0;
      post_cnt_q    <= '0;
      dec_cnt_q     <= '0;
      prev_above_q  <= 1'b0;
      prev_valid_q  <= 1'b0;
      frame_ready_q <= 1'b0;
      busy_q        <= 1'b0;
    end else if (arm) begin
      state_q       <= ST_PRE;
      pre_cnt_q     <= '0;
      post_cnt_q    <= '0;
      dec_cnt_q     <= decim;
      prev_above_q  <= 1'b0;
      prev_valid_q  <= 1'b0;
      frame_ready_q <= 1'b0;
      busy_q        <= 1'b1;
    end else if (busy_q && sample_valid) begin
      if (dec_cnt_q != '0) begin
        dec_cnt_q <= dec_cnt_q - 1'b1;
      end else begin
        dec_cnt_q    <= decim;
        wr_ptr_q     <= wr_ptr_q + 1'b1;
        prev_above_q <= above;
        prev_valid_q <= 1'b1;
        case (state_q)
          ST_PRE: begin
            pre_cnt_q <= pre_cnt_q + 1'b1;
            if (pre_cnt_q == HALF_M1) state_q <= ST_WAIT;
          end
          ST_WAIT: begin
            // the trigger sample itself is the first post-trigger sample
            if (hit) begin
              trig_ptr_q <= wr_ptr_q;
              post_cnt_q <= DEPTH_LOG2'(1);
              state_q    <= ST_POST;
            end
          end
          ST_POST: begin
            post_cnt_q <= post_cnt_q + 1'b1;
            if (post_cnt_q == HALF_M1) begin
              state_q       <= ST_DONE;
              busy_q        <= 1'b0;
              frame_ready_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  scope_ram #(
    .W  (2 * DATA_W),
    .AW (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (store_d),
    .waddr_i (wr_ptr_q),
    .wdata_i ({audio_l, audio_r}),
    .raddr_i (raddr_d),
    .rdata_o (rd_data)
  );

  assign frame_ready = frame_ready_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_scope_capture.sv
// Directed bench for scope_capture with a 16-entry frame (8 pre, 8 post).
module tb_scope_capture;

  localparam int DW  = 24;
  localparam int AW  = 4;
  localparam int DCW = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 sample_valid = 1'b0;
  logic signed [DW-1:0] audio_l = '0;
  logic signed [DW-1:0] audio_r = '0;
  logic                 chan_sel = 1'b0;
  logic [1:0]           trig_mode = 2'd0;
  logic signed [DW-1:0] trig_level = '0;
  logic [DCW-1:0]       decim = '0;
  logic                 arm = 1'b0;
  logic [AW-1:0]        rd_addr = '0;
  logic [2*DW-1:0]      rd_data;
  logic                 frame_ready;
  logic                 busy;

  int checks   = 0;
  int failures = 0;

  scope_capture #(
    .DATA_W     (DW),
    .DEPTH_LOG2 (AW),
    .DECIM_W    (DCW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .audio_l      (audio_l),
    .audio_r      (audio_r),
    .chan_sel     (chan_sel),
    .trig_mode    (trig_mode),
    .trig_level   (trig_level),
    .decim        (decim),
    .arm          (arm),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .frame_ready  (frame_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*DW-1:0] pack(input int l, input int r);
    logic [DW-1:0] a, b;
    a = DW'(l);
    b = DW'(r);
    return {a, b};
  endfunction

  task automatic check(input string tag, input logic [2*DW-1:0] obs,
                       input logic [2*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int l, input int r);
    audio_l      = DW'(l);
    audio_r      = DW'(r);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic rd(input int a, input int l, input int r, input string tag);
    rd_addr = AW'(a);
    tick();
    check(tag, rd_data, pack(l, r));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    tick();
    tick();
    check("reset_busy", (2*DW)'(busy), '0);
    check("reset_ready", (2*DW)'(frame_ready), '0);
    check("reset_rd_data", rd_data, '0);
    rst_n = 1'b1;
    tick();

    // 1: rising trigger on left ramp
    decim = '0; chan_sel = 1'b0; trig_mode = 2'd0; trig_level = '0;
    do_arm();
    check("t1_busy", (2*DW)'(busy), (2*DW)'(1));
    for (int v = -20; v <= 6; v++) send(v, 0);
    check("t1_not_ready", (2*DW)'(frame_ready), '0);
    send(7, 0);
    check("t1_ready", (2*DW)'(frame_ready), (2*DW)'(1));
    check("t1_idle", (2*DW)'(busy), '0);
    for (int v = 8; v <= 20; v++) send(v, 0);
    rd(8, 0, 0, "t1_rd8");
    rd(7, -1, 0, "t1_rd7");
    rd(15, 7, 0, "t1_rd15");
    rd(0, -8, 0, "t1_rd0");

    // 2: falling trigger on right
    chan_sel = 1'b1; trig_level = 100; trig_mode = 2'd1;
    do_arm();
    check("t2_arm_clears_ready", (2*DW)'(frame_ready), '0);
    for (int k = 0; k < 9; k++) send(5, 200);
    send(5, 150);
    send(5, 99);
    for (int k = 0; k < 7; k++) send(5, 98 - k);
    check("t2_ready", (2*DW)'(frame_ready), (2*DW)'(1));
    rd(8, 5, 99, "t2_rd8");
    rd(7, 5, 150, "t2_rd7");
    rd(9, 5, 98, "t2_rd9");
    trig_mode = 2'd0;
    do_arm();
    for (int k = 0; k < 9; k++) send(5, 200);
    send(5, 150);
    send(5, 99);
    for (int k = 0; k < 7; k++) send(5, 98 - k);
    check("t2_rise_no_ready", (2*DW)'(frame_ready), '0);
    check("t2_rise_busy", (2*DW)'(busy), (2*DW)'(1));

    // 3: decimation by 4, free-run; first stored sample is the 4th after arm
    decim = 8'd3; trig_mode = 2'd2; chan_sel = 1'b0;
    do_arm();
    for (int k = 0; k < 64; k++) send(k - 3, 0);
    check("t3_ready", (2*DW)'(frame_ready), (2*DW)'(1));
    for (int a = 0; a < 16; a++) rd(a, 4 * a, 0, "t3_rd");

    // 4: long wait before crossing wraps the ring
    decim = '0; trig_mode = 2'd0; trig_level = '0;
    do_arm();
    for (int k = 0; k < 45; k++) send(k - 1000, 0);
    check("t4_waiting", (2*DW)'(busy), (2*DW)'(1));
    send(500, 0);
    for (int k = 1; k < 8; k++) send(500 + k, 0);
    check("t4_ready", (2*DW)'(frame_ready), (2*DW)'(1));
    for (int a = 0; a < 8; a++) rd(a, 37 + a - 1000, 0, "t4_rd_pre");
    rd(8, 500, 0, "t4_rd8");

    // 5: re-arm in POST, then arm coincident with a sample
    trig_mode = 2'd2;
    do_arm();
    for (int k = 0; k < 12; k++) send(300 + k, 1);
    do_arm();
    check("t5_rearm_busy", (2*DW)'(busy), (2*DW)'(1));
    check("t5_rearm_ready", (2*DW)'(frame_ready), '0);
    for (int k = 0; k < 3; k++) send(400 + k, 1);
    audio_l = DW'(7777);
    arm = 1'b1;
    sample_valid = 1'b1;
    tick();
    arm = 1'b0;
    sample_valid = 1'b0;
    tick();
    tick();
    tick();
    for (int k = 0; k < 15; k++) send(1000 + k, 1);
    check("t5_not_ready", (2*DW)'(frame_ready), '0);
    send(1015, 1);
    check("t5_ready", (2*DW)'(frame_ready), (2*DW)'(1));
    rd(0, 1000, 1, "t5_rd0");
    rd(8, 1008, 1, "t5_rd8");
    rd(15, 1015, 1, "t5_rd15");

    // 6: asynchronous reset during POST
    do_arm();
    for (int k = 0; k < 11; k++) send(2000 + k, 2);
    rd(8, 2008, 2, "t6_rd8");
    check("t6_busy_before", (2*DW)'(busy), (2*DW)'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", (2*DW)'(busy), '0);
    check("t6_ready", (2*DW)'(frame_ready), '0);
    check("t6_rd_data", rd_data, '0);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
